q15_multiplier: RTL and testbench
=================================

Name: q15_multiplier

Overview:
- Pipelined signed fixed-point multiplier for the shading datapath.
- Operands and result are 64-bit two's-complement Q16.48: sign plus 15 integer bits, then 48 fraction bits. For example, 0x0001_2000_0000_0000 = 1.125.
- Three codes are reserved as special values: +Inf = 0x7FFF_FFFF_FFFF_FFFF, -Inf = 0xFFFF_FFFF_FFFF_FFFF, NaN = 0x8000_0000_0000_0000.
- The block saturates overflow to ±Inf and propagates special values. It accepts one operation per cycle with fixed latency.

Parameters:
- None. Format is fixed at Q16.48 and latency is fixed at 3 cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b valid this cycle; sampled on the rising clk edge.
- a  input  64  signed Q16.48 operand.
- b  input  64  signed Q16.48 operand.
- out_valid  output  1  res carries a new result this cycle.
- res  output  64  signed Q16.48 product or special code.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, res=0, all internal valid bits and data registers cleared. In-flight operations are discarded, with no output for them after reset releases.
- Throughput and latency:
  - No backpressure; the block accepts one operation every cycle.
  - An operation sampled with in_valid=1 at edge N produces out_valid=1 with its res after edge N+3.
  - Results appear in issue order.
  - When out_valid=0, res holds its last value.
- Pipeline:
  - S1: register operands; classify each as NaN, +Inf, -Inf, zero or finite.
  - S2: four 32x32 unsigned partial products of the operand magnitudes, plus the sign.
  - S3: sum, shift, round, saturate and apply special-value rules.
- Special-value rules, in priority order:
  - Either operand NaN -> NaN.
  - Infinity × zero -> NaN.
  - Both operands infinite, opposite signs -> NaN.
  - Both operands infinite, same sign -> +Inf.
  - One infinity × finite nonzero -> Inf whose sign is the XOR of the operand signs.
- Finite arithmetic:
  - Exact product P = a×b (128-bit signed); result R = P / 2^48, truncated toward zero.
  - Max finite value = 0x7FFF_FFFF_FFFF_FFFE; min finite value = 0x8000_0000_0000_0001.
  - R > max finite -> +Inf; R < min finite -> -Inf.
  - R = -2^-48 (code 0xFFFF_FFFF_FFFF_FFFF, which collides with -Inf) -> 0.
  - Zero operand -> 0 (never -0; no negative zero exists).
- Boundary cases:
  - 0x8000_0000_0000_0001 is a valid finite input, ≈ -32768.
  - Back-to-back operations with alternating special and finite inputs must not interfere.
  - in_valid may toggle every cycle; gaps propagate as out_valid=0.

Test Plan:
- Basic: a=0x0001_2000_0000_0000 (1.125), b=0x0008_0000_0000_0000 (8), in_valid for 1 cycle -> exactly 3 edges later out_valid=1, res=0x0009_0000_0000_0000. Sign variant: b=0xFFF8_0000_0000_0000 (-8) -> res=0xFFF7_0000_0000_0000.
- Overflow: a=0x0002_0000_0000_0000, b=0x7FFF_0000_0000_0000 -> res=0x7FFF_FFFF_FFFF_FFFF. Negative overflow: a=0x0002_0000_0000_0000, b=0x8000_0000_0000_0001 -> res=0xFFFF_FFFF_FFFF_FFFF.
- Specials:
  - a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000.
  - +Inf × +Inf -> +Inf.
  - +Inf × 0 -> NaN.
  - NaN × 1.0 -> NaN.
  - -Inf × 0xFFFE_0000_0000_0000 (-2) -> +Inf.
- Precision: a=0x0000_0000_0000_0001 × b=0xFFFF_0000_0000_0000 (-1) -> 0; 0x0000_8000_0000_0000 (0.5) × 0x0000_8000_0000_0000 -> 0x0000_4000_0000_0000.
- Streaming: 8 random finite pairs on consecutive cycles, with a one-cycle in_valid gap inserted -> results match a 128-bit reference model, in order, with a matching out_valid gap.
- Reset mid-flight: issue 2 operations, assert rst_n low one cycle later -> out_valid and res go to 0 immediately (no clock edge needed), and no stale results appear after release.

Source files
------------

// File: rtl/q15_multiplier.sv
// Signed Q16.48 multiplier: saturates to +/-Inf, propagates NaN/Inf, truncates toward zero.
// Latency 3 cycles (in at edge N, out after edge N+3); one op per cycle, no backpressure.
module q15_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  output logic [63:0] res
);

  localparam logic [63:0] POS_INF   = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_INF   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NAN_CODE  = 64'h8000_0000_0000_0000;
  localparam logic [79:0] POS_LIMIT = 80'h7FFF_FFFF_FFFF_FFFE;
  localparam logic [79:0] NEG_LIMIT = 80'h7FFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    CLS_FIN,
    CLS_ZERO,
    CLS_PINF,
    CLS_NINF,
    CLS_NAN
  } cls_t;

  function automatic cls_t classify(input logic [63:0] x);
    cls_t c;
    c = CLS_FIN;
    if (x == NAN_CODE)     c = CLS_NAN;
    else if (x == POS_INF) c = CLS_PINF;
    else if (x == NEG_INF) c = CLS_NINF;
    else if (x == '0)      c = CLS_ZERO;
    return c;
  endfunction

  // Stage 1: operands and their classes
  logic        s1_vld;
  logic [63:0] s1_a, s1_b;
  cls_t        s1_cls_a, s1_cls_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cls_a <= CLS_FIN;
      s1_cls_b <= CLS_FIN;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a     <= a;
        s1_b     <= b;
        s1_cls_a <= classify(a);
        s1_cls_b <= classify(b);
      end
    end
  end

  logic [63:0] mag_a, mag_b;
  logic        a_inf, b_inf, any_nan, inf_times_zero, prod_neg;
  logic        spec_hit;
  logic [63:0] spec_res;

  assign mag_a          = s1_a[63] ? (~s1_a + 64'd1) : s1_a;
  assign mag_b          = s1_b[63] ? (~s1_b + 64'd1) : s1_b;
  assign a_inf          = (s1_cls_a == CLS_PINF) || (s1_cls_a == CLS_NINF);
  assign b_inf          = (s1_cls_b == CLS_PINF) || (s1_cls_b == CLS_NINF);
  assign any_nan        = (s1_cls_a == CLS_NAN) || (s1_cls_b == CLS_NAN);
  assign inf_times_zero = (a_inf && (s1_cls_b == CLS_ZERO)) || (b_inf && (s1_cls_a == CLS_ZERO));
  // Bit 63 doubles as the sign of both infinity codes
  assign prod_neg       = s1_a[63] ^ s1_b[63];

  always_comb begin
    spec_hit = 1'b1;
    spec_res = NAN_CODE;
    if (any_nan || inf_times_zero) begin
      spec_res = NAN_CODE;
    end else if (a_inf && b_inf) begin
      spec_res = prod_neg ? NAN_CODE : POS_INF;
    end else if (a_inf || b_inf) begin
      spec_res = prod_neg ? NEG_INF : POS_INF;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Stage 2: partial products of magnitudes
  logic        s2_vld, s2_neg, s2_spec;
  logic [63:0] s2_spec_res;
  logic [63:0] s2_hh, s2_hl, s2_lh, s2_ll;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld      <= 1'b0;
      s2_neg      <= 1'b0;
      s2_spec     <= 1'b0;
      s2_spec_res <= '0;
      s2_hh       <= '0;
      s2_hl       <= '0;
      s2_lh       <= '0;
      s2_ll       <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_neg      <= prod_neg;
        s2_spec     <= spec_hit;
        s2_spec_res <= spec_res;
        s2_hh       <= {32'd0, mag_a[63:32]} * {32'd0, mag_b[63:32]};
        s2_hl       <= {32'd0, mag_a[63:32]} * {32'd0, mag_b[31:0]};
        s2_lh       <= {32'd0, mag_a[31:0]}  * {32'd0, mag_b[63:32]};
        s2_ll       <= {32'd0, mag_a[31:0]}  * {32'd0, mag_b[31:0]};
      end
    end
  end

  // Stage 3: summed magnitude already scaled by 2^-48 (truncation toward zero)
  logic        s3_vld, s3_neg, s3_spec;
  logic [63:0] s3_spec_res;
  logic [79:0] s3_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld      <= 1'b0;
      s3_neg      <= 1'b0;
      s3_spec     <= 1'b0;
      s3_spec_res <= '0;
      s3_mag      <= '0;
    end else begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_neg      <= s2_neg;
        s3_spec     <= s2_spec;
        s3_spec_res <= s2_spec_res;
        s3_mag      <= 80'(({s2_hh, 64'd0} + {32'd0, s2_hl, 32'd0} +
                            {32'd0, s2_lh, 32'd0} + {64'd0, s2_ll}) >> 48);
      end
    end
  end

  logic [63:0] res_nxt;

  always_comb begin
    res_nxt = '0;
    if (s3_spec) begin
      res_nxt = s3_spec_res;
    end else if (s3_mag == '0) begin
      res_nxt = '0;
    end else if (!s3_neg) begin
      res_nxt = (s3_mag > POS_LIMIT) ? POS_INF : s3_mag[63:0];
    end else if (s3_mag > NEG_LIMIT) begin
      res_nxt = NEG_INF;
    end else if (s3_mag == 80'd1) begin
      // -2^-48 would alias the -Inf code
      res_nxt = '0;
    end else begin
      res_nxt = ~s3_mag[63:0] + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
    end else begin
      out_valid <= s3_vld;
      if (s3_vld) res <= res_nxt;
    end
  end

endmodule

// File: tb/tb_q15_multiplier.sv
// Directed bench for q15_multiplier: fixed vectors, bursts with gaps, mid-flight reset.
module tb_q15_multiplier;

  localparam logic [63:0] POS_INF  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_INF  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NAN_CODE = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONE      = 64'h0001_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a, b;
  logic        out_valid;
  logic [63:0] res;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] ba[12], bb[12], bexp[12];
  logic        bv[12];
  int          blen;

  q15_multiplier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .res      (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent 128-bit reference for finite operands
  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] p, r;
    p = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y});
    r = p / 128'sd281474976710656;
    if (r > 128'sd9223372036854775806) return POS_INF;
    if (r < -128'sd9223372036854775807) return NEG_INF;
    if (r == -128'sd1) return 64'd0;
    return r[63:0];
  endfunction

  function automatic logic [63:0] rand_fin();
    logic [55:0] r;
    logic [63:0] x;
    r = 56'({$urandom, $urandom});
    x = {{8{r[55]}}, r};
    if (x == 64'd0 || x == NEG_INF) x = 64'h0000_0001_8000_0000;
    return x;
  endfunction

  // One operation, then verify the exact 3-edge latency
  task automatic single(input string tag, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp);
    in_valid = 1'b1;
    a = x;
    b = y;
    step();
    in_valid = 1'b0;
    step();
    step();
    check({tag, "_early"}, 64'(out_valid), 64'd0);
    step();
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_res"}, res, exp);
  endtask

  task automatic run_burst(input string tag);
    logic [63:0] last_res;
    int s;
    last_res = '0;
    for (int t = 0; t < blen + 3; t++) begin
      if (t < blen) begin
        in_valid = bv[t];
        a = ba[t];
        b = bb[t];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (t >= 3) begin
        s = t - 3;
        check($sformatf("%s_vld%0d", tag, s), 64'(out_valid), 64'(bv[s]));
        if (bv[s]) begin
          check($sformatf("%s_res%0d", tag, s), res, bexp[s]);
          last_res = bexp[s];
        end else begin
          check($sformatf("%s_hold%0d", tag, s), res, last_res);
        end
      end else begin
        check($sformatf("%s_fill%0d", tag, t), 64'(out_valid), 64'd0);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #3;
    check("reset_vld", 64'(out_valid), 64'd0);
    check("reset_res", res, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    single("basic",     64'h0001_2000_0000_0000, 64'h0008_0000_0000_0000, 64'h0009_0000_0000_0000);
    single("basic_neg", 64'h0001_2000_0000_0000, 64'hFFF8_0000_0000_0000, 64'hFFF7_0000_0000_0000);
    single("ovf_pos",   64'h0002_0000_0000_0000, 64'h7FFF_0000_0000_0000, POS_INF);
    single("ovf_neg",   64'h0002_0000_0000_0000, 64'h8000_0000_0000_0001, NEG_INF);
    single("pinf_ninf", POS_INF, NEG_INF, NAN_CODE);
    single("pinf_pinf", POS_INF, POS_INF, POS_INF);
    single("pinf_zero", POS_INF, 64'd0, NAN_CODE);
    single("nan_one",   NAN_CODE, ONE, NAN_CODE);
    single("ninf_neg2", NEG_INF, 64'hFFFE_0000_0000_0000, POS_INF);
    single("tiny_neg",  64'h0000_0000_0000_0001, 64'hFFFF_0000_0000_0000, 64'd0);
    single("half_half", 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000, 64'h0000_4000_0000_0000);

    // Random finite stream with a one-cycle gap at slot 4
    blen = 9;
    for (int i = 0; i < 9; i++) begin
      ba[i]   = rand_fin();
      bb[i]   = rand_fin();
      bv[i]   = (i != 4);
      bexp[i] = ref_mul(ba[i], bb[i]);
    end
    run_burst("stream");

    // Alternating special and finite operations back to back
    blen = 8;
    ba[0] = NAN_CODE;                bb[0] = 64'h0008_0000_0000_0000; bexp[0] = NAN_CODE;
    ba[1] = 64'h0001_2000_0000_0000; bb[1] = 64'h0008_0000_0000_0000; bexp[1] = 64'h0009_0000_0000_0000;
    ba[2] = POS_INF;                 bb[2] = 64'hFFFE_0000_0000_0000; bexp[2] = NEG_INF;
    ba[3] = 64'h0000_8000_0000_0000; bb[3] = 64'h0000_8000_0000_0000; bexp[3] = 64'h0000_4000_0000_0000;
    ba[4] = 64'd0;                   bb[4] = NEG_INF;                 bexp[4] = NAN_CODE;
    ba[5] = 64'h8000_0000_0000_0001; bb[5] = ONE;                     bexp[5] = 64'h8000_0000_0000_0001;
    ba[6] = 64'h7FFF_FFFF_FFFF_FFFE; bb[6] = ONE;                     bexp[6] = 64'h7FFF_FFFF_FFFF_FFFE;
    ba[7] = 64'hFFFF_0000_0000_0000; bb[7] = 64'h0003_0000_0000_0000; bexp[7] = 64'hFFFD_0000_0000_0000;
    for (int i = 0; i < 8; i++) bv[i] = 1'b1;
    run_burst("mixed");

    // Reset while operations are in flight
    in_valid = 1'b1;
    a = 64'h0001_2000_0000_0000;
    b = 64'h0008_0000_0000_0000;
    step();
    a = 64'h0000_8000_0000_0000;
    b = 64'h0000_8000_0000_0000;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("pre_rst_vld", 64'(out_valid), 64'd1);
    check("pre_rst_res", res, 64'h0009_0000_0000_0000);
    #2;
    rst_n = 1'b0;
    #2;
    check("async_rst_vld", 64'(out_valid), 64'd0);
    check("async_rst_res", res, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("post_rst_vld%0d", i), 64'(out_valid), 64'd0);
    end
    check("post_rst_res", res, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
